fc_layer_seq: RTL and testbench



---
 rtl/fc_layer_seq.sv | 167 ++++++++++++++++
 tb/tb_fc_layer_seq.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_seq.sv
// fc_layer_seq: time-multiplexed fully-connected layer.
// One signed MAC per clock, then one activation cycle per neuron
// (bias add, arithmetic shift, ReLU with saturation, running argmax).
// Results and the one-hot class are registered on entry to DONE, so
// they are valid during the done pulse and hold until the next one.
module fc_layer_seq #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 7,
  parameter int DW    = 8,
  parameter int WW    = 8,
  parameter int SHIFT = 0,
  localparam int ACC_W = DW + WW + $clog2(N_IN) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [N_IN*DW-1:0]       x_flat,
  input  logic [N_OUT*N_IN*WW-1:0] w_flat,
  input  logic [N_OUT*ACC_W-1:0]   b_flat,
  output logic                     busy,
  output logic                     done,
  output logic [N_OUT*DW-1:0]      y_flat,
  output logic [N_OUT-1:0]         class_onehot
);

  localparam int KW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int NW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int KD = 1 << KW;
  localparam int ND = 1 << NW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_ACT  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((1 << (DW - 1)) - 1);

  logic [1:0]              state;
  logic [N_IN*DW-1:0]      x_reg;
  logic signed [ACC_W-1:0] acc;
  logic [KW-1:0]           k;
  logic [NW-1:0]           n;
  logic [DW-1:0]           best_val;
  logic [NW-1:0]           best_idx;
  logic [DW-1:0]           y_int [ND];

  // Unpacked views padded to power-of-two depth so counters index them exactly
  logic signed [DW-1:0]    x_arr [KD];
  logic signed [WW-1:0]    w_arr [ND][KD];
  logic signed [ACC_W-1:0] b_arr [ND];

  for (genvar gk = 0; gk < KD; gk++) begin : g_x
    if (gk < N_IN) begin : g_xv
      assign x_arr[gk] = x_reg[gk*DW +: DW];
    end else begin : g_xz
      assign x_arr[gk] = '0;
    end
  end

  for (genvar gn = 0; gn < ND; gn++) begin : g_n
    for (genvar gk = 0; gk < KD; gk++) begin : g_k
      if (gn < N_OUT && gk < N_IN) begin : g_wv
        assign w_arr[gn][gk] = w_flat[(gn*N_IN+gk)*WW +: WW];
      end else begin : g_wz
        assign w_arr[gn][gk] = '0;
      end
    end
    if (gn < N_OUT) begin : g_bv
      assign b_arr[gn] = b_flat[gn*ACC_W +: ACC_W];
    end else begin : g_bz
      assign b_arr[gn] = '0;
    end
  end

  logic signed [DW+WW-1:0] prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] shifted;
  logic [DW-1:0]           y_cur;
  logic                    take;
  logic [NW-1:0]           idx_next;
  logic [N_OUT*DW-1:0]     y_next;

  // MAC product, activation of the current neuron and argmax decision
  always_comb begin
    prod     = x_arr[k] * w_arr[n][k];
    prod_ext = {{(ACC_W-DW-WW){prod[DW+WW-1]}}, prod};
    sum      = acc + b_arr[n];
    shifted  = sum >>> SHIFT;
    if (shifted < 0) begin
      y_cur = '0;
    end else if (shifted > Y_MAX) begin
      y_cur = Y_MAX[DW-1:0];
    end else begin
      y_cur = shifted[DW-1:0];
    end
    take     = (n == '0) || (y_cur > best_val);
    idx_next = take ? n : best_idx;
  end

  // Final result vector includes the neuron being activated this cycle
  for (genvar gy = 0; gy < N_OUT; gy++) begin : g_y
    assign y_next[gy*DW +: DW] = (n == NW'(gy)) ? y_cur : y_int[gy];
  end

  // Handshake status decoded from state
  always_comb begin
    busy = (state == S_MAC) || (state == S_ACT);
    done = (state == S_DONE);
  end

  // Sequencer: IDLE -> (N_IN x MAC, ACT) per neuron -> DONE -> IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      x_reg        <= '0;
      acc          <= '0;
      k            <= '0;
      n            <= '0;
      best_val     <= '0;
      best_idx     <= '0;
      y_int        <= '{default: '0};
      y_flat       <= '0;
      class_onehot <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            x_reg <= x_flat;
            acc   <= '0;
            k     <= '0;
            n     <= '0;
            state <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= acc + prod_ext;
          if (k == KW'(N_IN - 1)) begin
            state <= S_ACT;
          end else begin
            k <= k + 1'b1;
          end
        end
        S_ACT: begin
          y_int[n] <= y_cur;
          if (take) begin
            best_val <= y_cur;
            best_idx <= n;
          end
          acc <= '0;
          k   <= '0;
          if (n == NW'(N_OUT - 1)) begin
            y_flat       <= y_next;
            class_onehot <= N_OUT'(1) << idx_next;
            state        <= S_DONE;
          end else begin
            n     <= n + 1'b1;
            state <= S_MAC;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_seq.sv
// Testbench for fc_layer_seq: default configuration, a SHIFT=2 instance
// and a minimal N_IN=1/N_OUT=2/4-bit instance, with a result scoreboard.
module tb_fc_layer_seq;

  typedef struct packed {
    logic [63:0] y;
    logic [7:0]  oh;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         rst, start_a, start_b, start_c;
  logic [31:0]  x_a;
  logic [223:0] w_a;
  logic [132:0] b_a;
  logic         busy_a, done_a, busy_b, done_b, busy_c, done_c;
  logic [55:0]  y_a, y_b;
  logic [6:0]   oh_a, oh_b;
  logic [3:0]   x_c;
  logic [7:0]   w_c;
  logic [17:0]  b_c;
  logic [7:0]   y_c;
  logic [1:0]   oh_c;

  fc_layer_seq u_a (
    .clk(clk), .rst(rst), .start(start_a), .x_flat(x_a), .w_flat(w_a), .b_flat(b_a),
    .busy(busy_a), .done(done_a), .y_flat(y_a), .class_onehot(oh_a)
  );

  fc_layer_seq #(.SHIFT(2)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .x_flat(x_a), .w_flat(w_a), .b_flat(b_a),
    .busy(busy_b), .done(done_b), .y_flat(y_b), .class_onehot(oh_b)
  );

  fc_layer_seq #(.N_IN(1), .N_OUT(2), .DW(4), .WW(4)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .x_flat(x_c), .w_flat(w_c), .b_flat(b_c),
    .busy(busy_c), .done(done_c), .y_flat(y_c), .class_onehot(oh_c)
  );

  logic [2:0]  done_v, busy_v;
  logic [63:0] y_v [3];
  logic [7:0]  oh_v [3];
  assign done_v  = {done_c, done_b, done_a};
  assign busy_v  = {busy_c, busy_b, busy_a};
  assign y_v[0]  = 64'(y_a);
  assign y_v[1]  = 64'(y_b);
  assign y_v[2]  = 64'(y_c);
  assign oh_v[0] = 8'(oh_a);
  assign oh_v[1] = 8'(oh_b);
  assign oh_v[2] = 8'(oh_c);

  int   n_pass = 0;
  int   n_total = 0;
  int   n_fail = 0;
  exp_t sb [$];
  int   mx [4];
  int   mw [7][4];
  int   mb [7];
  int   done_cyc = 0;
  int   prev_done_cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic expect_res(input logic [63:0] y, input logic [7:0] oh);
    exp_t e;
    e.y  = y;
    e.oh = oh;
    sb.push_back(e);
  endtask

  task automatic set_start(input int which, input logic v);
    case (which)
      0:       start_a = v;
      1:       start_b = v;
      default: start_c = v;
    endcase
  endtask

  task automatic drive();
    for (int k = 0; k < 4; k++) x_a[k*8 +: 8] = 8'(mx[k]);
    for (int n = 0; n < 7; n++) begin
      b_a[n*19 +: 19] = 19'(mb[n]);
      for (int k = 0; k < 4; k++) w_a[(n*4+k)*8 +: 8] = 8'(mw[n][k]);
    end
    x_c = 4'(mx[0]);
    w_c = {4'(mw[1][0]), 4'(mw[0][0])};
    b_c = {9'(mb[1]), 9'(mb[0])};
  endtask

  task automatic load_known(input int bias);
    for (int k = 0; k < 4; k++) mx[k] = k + 1;
    for (int n = 0; n < 7; n++) begin
      mb[n] = bias;
      for (int k = 0; k < 4; k++) mw[n][k] = n + 1;
    end
    drive();
  endtask

  task automatic load_fill(input int xv, input int wv, input int bv);
    for (int k = 0; k < 4; k++) mx[k] = xv;
    for (int n = 0; n < 7; n++) begin
      mb[n] = bv;
      for (int k = 0; k < 4; k++) mw[n][k] = wv;
    end
    drive();
  endtask

  // Integer reference: dot product, shift, clamp, first-maximum argmax
  function automatic exp_t model(input int nin, input int nout, input int dw, input int sh);
    exp_t e;
    int   s, ymax, best, bi;
    e    = '0;
    ymax = (1 << (dw - 1)) - 1;
    best = -1;
    bi   = 0;
    for (int n = 0; n < nout; n++) begin
      s = mb[n];
      for (int k = 0; k < nin; k++) s += mx[k] * mw[n][k];
      s = s >>> sh;
      if (s < 0) s = 0;
      else if (s > ymax) s = ymax;
      e.y = e.y | (64'(s) << (n * dw));
      if (s > best) begin
        best = s;
        bi   = n;
      end
    end
    e.oh = 8'(1) << bi;
    return e;
  endfunction

  // Start one evaluation, optionally re-pulse start at given cycle offsets,
  // wait (bounded) for done and compare latency, busy and scoreboard entry.
  task automatic eval(input int which, input string tag, input int exp_lat,
                      input int p1, input int p2, input int p3);
    int   lat;
    logic busy_ok;
    exp_t e;
    @(posedge clk); #1 set_start(which, 1'b1);
    @(posedge clk); #1 set_start(which, 1'b0);
    lat     = 0;
    busy_ok = 1'b1;
    while (!done_v[which] && lat < 100) begin
      if (!busy_v[which]) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
      set_start(which, (lat == p1) || (lat == p2) || (lat == p3));
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " busy"}, {62'd0, busy_ok, busy_v[which]}, 64'd2);
    if (sb.size() == 0) begin
      check({tag, " scoreboard"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check({tag, " y"}, y_v[which], e.y);
      check({tag, " onehot"}, 64'(oh_v[which]), 64'(e.oh));
    end
    prev_done_cyc = done_cyc;
    done_cyc      = cyc;
  endtask

  initial begin
    int   nd;
    exp_t e;
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    load_fill(0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("reset busy", 64'({busy_a, busy_b, busy_c}), 64'd0);
    check("reset done", 64'({done_a, done_b, done_c}), 64'd0);
    check("reset y", 64'(y_a), 64'd0);
    check("reset onehot", 64'({oh_a, oh_c}), 64'd0);

    // All-zero run: tie keeps neuron 0
    expect_res(64'h0, 8'h01);
    eval(0, "zero", 35, -1, -1, -1);

    load_known(0);
    expect_res(64'h463C32281E140A, 8'h40);
    eval(0, "known", 35, -1, -1, -1);

    load_known(-35);
    expect_res(64'h23190F05000000, 8'h40);
    eval(0, "negbias", 35, -1, -1, -1);

    load_known(0);
    expect_res(64'h110F0C0A070502, 8'h40);
    eval(1, "shift2", 35, -1, -1, -1);

    load_fill(127, 127, 0);
    expect_res(64'h7F7F7F7F7F7F7F, 8'h01);
    eval(0, "saturate", 35, -1, -1, -1);

    // Start re-pulsed mid-run and held through DONE, then back-to-back run
    load_known(-35);
    expect_res(64'h23190F05000000, 8'h40);
    eval(0, "handshake", 35, 5, 34, 35);
    load_known(0);
    expect_res(64'h463C32281E140A, 8'h40);
    eval(0, "backtoback", 35, -1, -1, -1);
    check("done spacing", 64'(done_cyc - prev_done_cyc), 64'd37);

    nd = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done_a) nd++;
    end
    check("quiet", 64'(nd), 64'd0);

    // Reset at cycle 12 of an evaluation
    load_fill(3, 5, 0);
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("hold y", 64'(y_a), 64'h463C32281E140A);
    check("hold busy", 64'(busy_a), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("midrst busy", 64'(busy_a), 64'd0);
    check("midrst y", 64'(y_a), 64'd0);
    check("midrst onehot", 64'(oh_a), 64'd0);
    nd = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (done_a) nd++;
    end
    check("midrst nodone", 64'(nd), 64'd0);

    // rst and start together: reset wins
    rst = 1'b1;
    start_a = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    start_a = 1'b0;
    check("rst over start", 64'(busy_a), 64'd0);

    load_known(0);
    expect_res(64'h463C32281E140A, 8'h40);
    eval(0, "after reset", 35, -1, -1, -1);

    // Small configuration with random stimulus against the integer model
    for (int r = 0; r < 200; r++) begin
      mx[0]    = int'($urandom_range(15)) - 8;
      mw[0][0] = int'($urandom_range(15)) - 8;
      mw[1][0] = int'($urandom_range(15)) - 8;
      mb[0]    = int'($urandom_range(254)) - 127;
      mb[1]    = int'($urandom_range(254)) - 127;
      drive();
      e = model(1, 2, 4, 0);
      sb.push_back(e);
      eval(2, "sweep", 4, -1, -1, -1);
    end

    check("scoreboard empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
